evt_collector: RTL
==================

EVT_COLLECTOR -- requirements
Module: evt_collector

Interface
REQ-001 SHALL have parameter DP_GROUP, default 16: number of datapath input lanes.
REQ-002 SHALL have parameter CNT_WIDTH, default 16: width of the per-epoch spike counter.
REQ-003 SHALL have one clock, engine_clk_i; reset is engine_rst_ni, asynchronous and active-low.
REQ-004 Port: engine_clk_i  in  1  engine clock.
REQ-005 Port: engine_rst_ni  in  1  asynchronous active-low reset.
REQ-006 Port: clear_i  in  1  synchronous clear of the counter and the mismatch flag.
REQ-007 Port: evt_dp_stream_collector_dst  SNE_EVENT_STREAM.dst  [DP_GROUP]  per-lane datapath output streams (valid/ready/evt as uevent_t).
REQ-008 Port: evt_stream_collector_src  SNE_EVENT_STREAM.src  1  merged engine output stream.
REQ-009 Port: barrier_mismatch_o  out  1  sticky flag: lane barrier_ids disagreed at alignment.
REQ-010 Port: spike_count_o  out  CNT_WIDTH  spikes forwarded since the last emitted barrier.

Function
REQ-011 A lane head SHALL be a barrier iff valid and evt.synch.operation == EVT_TIME; otherwise, when valid, it is a spike.
REQ-012 Output SHALL be a single register stage: load_en = !src.valid || src.ready; src.evt SHALL be held stable while src.valid && !src.ready.
REQ-013 FSM states SHALL be COLLECT, EMIT, RELEASE; reset state COLLECT.
REQ-014 COLLECT: among lanes presenting spikes, SHALL grant one per cycle, round-robin: the lowest index >= rr_ptr among requesters, wrapping modulo DP_GROUP.
REQ-015 COLLECT: when a grant exists and load_en is high, the granted lane's ready SHALL be 1 for that cycle, its evt SHALL be loaded unchanged into the output register, and rr_ptr SHALL become (grant+1) mod DP_GROUP.
REQ-016 Latency from lane accept to src.valid SHALL be exactly 1 cycle.
REQ-017 A lane presenting a barrier SHALL NOT be granted or acknowledged in COLLECT.
REQ-018 COLLECT -> EMIT SHALL occur when all DP_GROUP lanes are valid and every head is a barrier; no lane is acknowledged in that cycle.
REQ-019 EMIT: when load_en is high, the output register SHALL be loaded with synch.operation = EVT_TIME and synch.barrier_id = lane 0 barrier_id, all other fields 0; state -> RELEASE. Otherwise the FSM SHALL remain in EMIT.
REQ-020 EMIT load cycle: if any lane barrier_id differs from lane 0, barrier_mismatch_o SHALL be set and remain set until clear_i or reset.
REQ-021 RELEASE: all DP_GROUP lane readys SHALL be 1 for exactly one cycle, spike_count_o SHALL be cleared, rr_ptr SHALL be left unchanged, and state -> COLLECT.
REQ-022 Lane readys SHALL be 0 in every cycle not covered by REQ-015 or REQ-021.
REQ-023 spike_count_o SHALL increment on each spike accept, saturating at all-ones (no wrap).
REQ-024 clear_i SHALL zero spike_count_o and barrier_mismatch_o next cycle; clear_i has priority over increment and set in the same cycle. clear_i SHALL NOT affect the FSM, rr_ptr or the output register.
REQ-025 Exactly one barrier event SHALL be emitted per alignment; spikes accepted before alignment SHALL precede it on the output.

Reset
REQ-026 On engine_rst_ni low: src.valid = 0, src.evt = 0, all lane readys = 0, state = COLLECT, rr_ptr = 0, spike_count_o = 0, barrier_mismatch_o = 0.
REQ-027 Reset asserted mid-handshake SHALL discard any held output event; no lane is acknowledged while reset is low.

Verification
REQ-028 Reset: assert engine_rst_ni low with random input activity -> all outputs at REQ-026 values, no lane ready.
REQ-029 Lanes 3 and 7 each present one spike in the same cycle, src.ready=1, rr_ptr=0 -> lane 3 output at T+1, lane 7 at T+2, rr_ptr=8, spike_count_o=2.
REQ-030 src.ready=0 for 5 cycles with src.valid=1 -> src.evt stable, all lane readys 0; ready returns -> next grant resumes.
REQ-031 Lanes 0-14 present barrier id 5; lane 15 presents a spike then barrier id 5 -> spike output first, then one EVT_TIME id 5, all readys high for one cycle, spike_count_o returns to 0.
REQ-032 Lane 9 presents barrier id 6, the others id 5 -> emitted barrier_id 5, barrier_mismatch_o=1 until clear_i pulses, then 0.
REQ-033 CNT_WIDTH=4, 20 spikes with no barrier -> spike_count_o=15 and held at 15.

Source files
------------

// File: rtl/evt_collector_if.sv
// Event type definitions and the valid/ready event stream interface shared by
// the collector, its datapath lanes and the engine output.
package sne_evt_pkg;

  typedef enum logic [1:0] {
    EVT_SPIKE  = 2'd0,
    EVT_TIME   = 2'd1,
    EVT_SYNC   = 2'd2,
    EVT_UPDATE = 2'd3
  } evt_op_e;

  typedef struct packed {
    evt_op_e    operation;
    logic [7:0] barrier_id;
  } synch_t;

  typedef struct packed {
    synch_t      synch;
    logic [19:0] payload;
  } uevent_t;

endpackage

interface SNE_EVENT_STREAM;
  logic                 valid;
  logic                 ready;
  sne_evt_pkg::uevent_t evt;

  modport src (output valid, output evt, input ready);
  modport dst (input valid, input evt, output ready);
endinterface

// File: rtl/evt_collector.sv
// Merges DP_GROUP lane event streams into one output stream: spikes are
// forwarded round-robin, and lane barriers are aligned into a single barrier event.
module evt_collector
  import sne_evt_pkg::*;
#(
  parameter int unsigned DP_GROUP  = 16,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 engine_clk_i,
  input  logic                 engine_rst_ni,
  input  logic                 clear_i,
  SNE_EVENT_STREAM.dst         evt_dp_stream_collector_dst [DP_GROUP],
  SNE_EVENT_STREAM.src         evt_stream_collector_src,
  output logic                 barrier_mismatch_o,
  output logic [CNT_WIDTH-1:0] spike_count_o
);

  localparam int unsigned PTR_W = (DP_GROUP > 1) ? $clog2(DP_GROUP) : 1;

  typedef enum logic [1:0] {COLLECT, EMIT, RELEASE} state_e;

  state_e               state_q, state_d;
  logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic                 valid_q, valid_d;
  uevent_t              evt_q, evt_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 mis_q, mis_d;

  logic [DP_GROUP-1:0]  lane_valid, lane_bar, spike_req, lane_ready, lane_ready_raw;
  uevent_t              lane_evt [DP_GROUP];
  logic                 src_ready, load_en, grant_vld, all_bar, id_mismatch;
  logic [PTR_W-1:0]     grant_idx, cand;

  for (genvar g = 0; g < DP_GROUP; g++) begin : g_lane
    assign lane_valid[g] = evt_dp_stream_collector_dst[g].valid;
    assign lane_evt[g]   = evt_dp_stream_collector_dst[g].evt;
    assign lane_bar[g]   = lane_valid[g] && (lane_evt[g].synch.operation == EVT_TIME);
    assign spike_req[g]  = lane_valid[g] && (lane_evt[g].synch.operation != EVT_TIME);
    assign evt_dp_stream_collector_dst[g].ready = lane_ready[g];
  end

  assign src_ready                    = evt_stream_collector_src.ready;
  assign evt_stream_collector_src.valid = valid_q;
  assign evt_stream_collector_src.evt   = evt_q;
  assign barrier_mismatch_o           = mis_q;
  assign spike_count_o                = cnt_q;

  assign load_en = !valid_q || src_ready;
  assign all_bar = &lane_bar;

  // First spike requester at or after rr_ptr, wrapping around the lane group
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int unsigned k = 0; k < DP_GROUP; k++) begin
      cand = PTR_W'((32'(rr_ptr_q) + k) % DP_GROUP);
      if (!grant_vld && spike_req[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  always_comb begin
    id_mismatch = 1'b0;
    for (int unsigned g = 1; g < DP_GROUP; g++) begin
      if (lane_evt[g].synch.barrier_id != lane_evt[0].synch.barrier_id) id_mismatch = 1'b1;
    end
  end

  always_comb begin
    state_d        = state_q;
    rr_ptr_d       = rr_ptr_q;
    valid_d        = valid_q;
    evt_d          = evt_q;
    cnt_d          = cnt_q;
    mis_d          = mis_q;
    lane_ready_raw = '0;
    if (load_en) valid_d = 1'b0;
    unique case (state_q)
      COLLECT: begin
        if (grant_vld && load_en) begin
          lane_ready_raw[grant_idx] = 1'b1;
          valid_d  = 1'b1;
          evt_d    = lane_evt[grant_idx];
          rr_ptr_d = PTR_W'((32'(grant_idx) + 32'd1) % DP_GROUP);
          if (cnt_q != '1) cnt_d = cnt_q + CNT_WIDTH'(1);
        end
        if (all_bar) state_d = EMIT;
      end
      EMIT: begin
        if (load_en) begin
          valid_d                  = 1'b1;
          evt_d                    = '0;
          evt_d.synch.operation    = EVT_TIME;
          evt_d.synch.barrier_id   = lane_evt[0].synch.barrier_id;
          if (id_mismatch) mis_d   = 1'b1;
          state_d                  = RELEASE;
        end
      end
      RELEASE: begin
        lane_ready_raw = '1;
        cnt_d          = '0;
        state_d        = COLLECT;
      end
      default: state_d = COLLECT;
    endcase
    if (clear_i) begin
      cnt_d = '0;
      mis_d = 1'b0;
    end
  end

  // Grants are combinational, so they must also be masked while reset is held
  assign lane_ready = engine_rst_ni ? lane_ready_raw : '0;

  always_ff @(posedge engine_clk_i or negedge engine_rst_ni) begin
    if (!engine_rst_ni) begin
      state_q  <= COLLECT;
      rr_ptr_q <= '0;
      valid_q  <= 1'b0;
      evt_q    <= '0;
      cnt_q    <= '0;
      mis_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      valid_q  <= valid_d;
      evt_q    <= evt_d;
      cnt_q    <= cnt_d;
      mis_q    <= mis_d;
    end
  end

endmodule
